// File: rtl/mem_responder_if.sv
// Bus bundle between the control sequencer (master) and the memory
// responder (slave): request strobes, MAR address, MDR write data, and the
// read data / completion / busy / error returns.
interface mem_responder_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              mem_ready;
  logic              busy;
  logic              err;

  modport master (
    output read, write, addr, wdata,
    input  rdata, mem_ready, busy, err
  );

  modport slave (
    input  read, write, addr, wdata,
    output rdata, mem_ready, busy, err
  );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder for the MAR/MDR interface. Captures a read or write
// request, waits WAIT_STATES cycles, performs one single-port word access,
// then pulses mem_ready for one cycle. HOLD stops a level-held strobe from
// retriggering. Simultaneous read+write is rejected with a one-cycle err.
// Optional feature macro: MEM_WRITE_PROTECT_EN (addresses below
// PROTECT_LIMIT become read-only; a blocked write pulses err with mem_ready).
module mem_responder #(
  parameter int ADDR_W        = 9,
  parameter int DATA_W        = 32,
  parameter int WAIT_STATES   = 1,
  parameter     INIT_FILE     = "",
  parameter int PROTECT_LIMIT = 16
) (
  input logic            clock,
  input logic            clear,
  mem_responder_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_HOLD
  } state_t;

  localparam logic [3:0] WS_RELOAD =
    (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
  localparam logic [ADDR_W:0] PROT_LIM = PROTECT_LIMIT[ADDR_W:0];

`ifdef MEM_WRITE_PROTECT_EN
  localparam bit PROTECT_ON = 1'b1;
`else
  localparam bit PROTECT_ON = 1'b0;
`endif

  logic [DATA_W-1:0] mem [2**ADDR_W];

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              capture;
  logic              do_access;
  logic              err_set;
  logic              wr_blocked;

  logic              op_write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              mem_ready_q;
  logic              err_q;

  // Write to a protected address is suppressed when the feature is built in
  assign wr_blocked = PROTECT_ON && op_write_q && ({1'b0, addr_q} < PROT_LIM);

  // Next-state and per-cycle control decode
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture   = 1'b0;
    do_access = 1'b0;
    err_set   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.read ^ bus.write) begin
          capture = 1'b1;
          cnt_d   = WS_RELOAD;
          state_d = (WAIT_STATES == 0) ? ST_ACCESS : ST_WAIT;
        end else if (bus.read && bus.write) begin
          err_set = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_ACCESS;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_ACCESS: begin
        do_access = 1'b1;
        state_d   = ST_HOLD;
      end
      ST_HOLD: begin
        if (!bus.read && !bus.write) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, wait counter and registered status pulses
  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      mem_ready_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_ready_q <= do_access;
      err_q       <= err_set | (do_access & wr_blocked);
    end
  end

  // Request capture; later changes on addr/wdata do not affect the access
  always_ff @(posedge clock) begin
    if (capture) begin
      op_write_q <= bus.write;
      addr_q     <= bus.addr;
      wdata_q    <= bus.wdata;
    end
  end

  // Read data register: only a read access updates it
  always_ff @(posedge clock) begin
    if (!clear)                       rdata_q <= '0;
    else if (do_access && !op_write_q) rdata_q <= mem[addr_q];
  end

  // Array write; reset on the access edge cancels the commit
  always_ff @(posedge clock) begin
    if (clear && do_access && op_write_q && !wr_blocked)
      mem[addr_q] <= wdata_q;
  end

  assign bus.rdata     = rdata_q;
  assign bus.mem_ready = mem_ready_q;
  assign bus.err       = err_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder (WAIT_STATES=1). Inputs change on the
// falling edge; outputs are sampled on the falling edge after each rising
// edge, so "after edge k+n" is the n-th sample following request setup.
module tb_mem_responder;

  logic clock;
  logic clear;
  int   checks;
  int   failures;

  mem_responder_if #(.ADDR_W(9), .DATA_W(32)) bus ();

  mem_responder #(
    .ADDR_W       (9),
    .DATA_W       (32),
    .WAIT_STATES  (1),
    .INIT_FILE    (""),
    .PROTECT_LIMIT(16)
  ) dut (
    .clock(clock),
    .clear(clear),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Issue one request, hold it 6 cycles, drop it, and return what was seen
  task automatic do_op(input logic rd, input logic wr, input logic [8:0] a,
                       input logic [31:0] d, output int rdy_n, output int rdy_at,
                       output int err_n, output logic [31:0] rv, output logic bz);
    rdy_n = 0; rdy_at = -1; err_n = 0;
    bus.read = rd; bus.write = wr; bus.addr = a; bus.wdata = d;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (bus.mem_ready) begin
        rdy_n++;
        if (rdy_at < 0) rdy_at = c;
      end
      if (bus.err) err_n++;
    end
    bus.read = 1'b0; bus.write = 1'b0;
    tick();
    rv = bus.rdata;
    bz = bus.busy;
  endtask

  task automatic test_reset();
    clear = 1'b0;
    bus.read = 1'b0; bus.write = 1'b0; bus.addr = '0; bus.wdata = '0;
    repeat (3) tick();
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.mem_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", bus.mem_ready); end
    checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus.err); end
    checks++; if (bus.rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", bus.rdata); end
    clear = 1'b1;
    tick();
  endtask

  task automatic test_write();
    bus.write = 1'b1; bus.addr = 9'h05A; bus.wdata = 32'h1234ABCD;
    tick(); // edge k
    checks++; if (bus.busy !== 1'b1 || bus.mem_ready !== 1'b0) begin failures++; $display("FAIL wr_k busy=%b ready=%b exp busy=1 ready=0", bus.busy, bus.mem_ready); end
    tick(); // k+1
    checks++; if (bus.mem_ready !== 1'b0) begin failures++; $display("FAIL wr_k1_ready got=%b exp=0", bus.mem_ready); end
    tick(); // k+2
    checks++; if (bus.mem_ready !== 1'b1 || bus.err !== 1'b0) begin failures++; $display("FAIL wr_k2 ready=%b err=%b exp ready=1 err=0", bus.mem_ready, bus.err); end
    tick(); // k+3, write still held
    checks++; if (bus.mem_ready !== 1'b0 || bus.busy !== 1'b1) begin failures++; $display("FAIL wr_k3 ready=%b busy=%b exp ready=0 busy=1", bus.mem_ready, bus.busy); end
    bus.write = 1'b0;
    tick(); // k+4
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL wr_hold_exit busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_readback();
    bus.read = 1'b1; bus.addr = 9'h05A;
    tick(); tick(); tick(); // k+2
    checks++; if (bus.mem_ready !== 1'b1) begin failures++; $display("FAIL rd_ready got=%b exp=1", bus.mem_ready); end
    checks++; if (bus.rdata !== 32'h1234ABCD) begin failures++; $display("FAIL rd_data got=%h exp=1234abcd", bus.rdata); end
    tick(); // k+3, read still held
    checks++; if (bus.mem_ready !== 1'b0 || bus.busy !== 1'b1) begin failures++; $display("FAIL rd_no_retrigger ready=%b busy=%b exp ready=0 busy=1", bus.mem_ready, bus.busy); end
    bus.read = 1'b0;
    tick();
    checks++; if (bus.busy !== 1'b0 || bus.rdata !== 32'h1234ABCD) begin failures++; $display("FAIL rd_exit busy=%b rdata=%h exp busy=0 rdata=1234abcd", bus.busy, bus.rdata); end
  endtask

  task automatic test_latch();
    int n, at, e; logic [31:0] rv; logic bz;
    do_op(1'b0, 1'b1, 9'h010, 32'h000000FF, n, at, e, rv, bz);
    do_op(1'b0, 1'b1, 9'h011, 32'h000000EE, n, at, e, rv, bz);
    bus.read = 1'b1; bus.addr = 9'h010;
    tick(); // k
    bus.addr = 9'h011;
    tick(); tick(); // k+2
    checks++; if (bus.mem_ready !== 1'b1 || bus.rdata !== 32'h000000FF) begin failures++; $display("FAIL latch ready=%b rdata=%h exp ready=1 rdata=000000ff", bus.mem_ready, bus.rdata); end
    bus.read = 1'b0;
    tick(); tick();
    // rdata must survive a write and idle cycles
    do_op(1'b0, 1'b1, 9'h1FF, 32'hA5A5_5A5A, n, at, e, rv, bz);
    checks++; if (rv !== 32'h000000FF || n != 1 || at != 2) begin failures++; $display("FAIL rdata_hold rdata=%h pulses=%0d at=%0d exp rdata=000000ff pulses=1 at=2", rv, n, at); end
  endtask

  task automatic test_simultaneous();
    int n, at, e; logic [31:0] rv; logic bz;
    do_op(1'b0, 1'b1, 9'h020, 32'h0BADF00D, n, at, e, rv, bz);
    bus.read = 1'b1; bus.write = 1'b1; bus.addr = 9'h020; bus.wdata = 32'hDEADBEEF;
    tick(); // k
    checks++; if (bus.err !== 1'b1 || bus.mem_ready !== 1'b0 || bus.busy !== 1'b1) begin failures++; $display("FAIL both_k err=%b ready=%b busy=%b exp 1/0/1", bus.err, bus.mem_ready, bus.busy); end
    n = 0; e = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (bus.mem_ready) n++;
      if (bus.err) e++;
    end
    checks++; if (n != 0 || e != 0) begin failures++; $display("FAIL both_after ready_pulses=%0d err_pulses=%0d exp 0/0", n, e); end
    bus.read = 1'b0; bus.write = 1'b0;
    tick();
    do_op(1'b1, 1'b0, 9'h020, 32'h0, n, at, e, rv, bz);
    checks++; if (rv !== 32'h0BADF00D || e != 0) begin failures++; $display("FAIL both_unchanged got=%h err=%0d exp=0badf00d err=0", rv, e); end
  endtask

  task automatic test_reset_mid();
    int n, at, e; logic [31:0] rv; logic bz;
    do_op(1'b0, 1'b1, 9'h030, 32'h13572468, n, at, e, rv, bz);
    do_op(1'b0, 1'b1, 9'h031, 32'h24681357, n, at, e, rv, bz);
    // reset while in WAIT
    bus.write = 1'b1; bus.addr = 9'h030; bus.wdata = 32'hCAFEF00D;
    tick(); // k: WAIT
    clear = 1'b0;
    tick();
    checks++; if (bus.busy !== 1'b0 || bus.rdata !== 32'h0 || bus.mem_ready !== 1'b0) begin failures++; $display("FAIL rst_wait busy=%b rdata=%h ready=%b exp 0/0/0", bus.busy, bus.rdata, bus.mem_ready); end
    bus.write = 1'b0; clear = 1'b1;
    n = 0;
    for (int c = 0; c < 4; c++) begin tick(); if (bus.mem_ready) n++; end
    checks++; if (n != 0) begin failures++; $display("FAIL rst_wait_ready pulses=%0d exp=0", n); end
    do_op(1'b1, 1'b0, 9'h030, 32'h0, n, at, e, rv, bz);
    checks++; if (rv !== 32'h13572468) begin failures++; $display("FAIL rst_wait_mem got=%h exp=13572468", rv); end
    // reset coincident with the ACCESS edge
    bus.write = 1'b1; bus.addr = 9'h031; bus.wdata = 32'hCAFEF00D;
    tick(); tick(); // now in ACCESS
    clear = 1'b0;
    tick();
    checks++; if (bus.mem_ready !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL rst_access ready=%b busy=%b exp 0/0", bus.mem_ready, bus.busy); end
    bus.write = 1'b0; clear = 1'b1;
    tick();
    do_op(1'b1, 1'b0, 9'h031, 32'h0, n, at, e, rv, bz);
    checks++; if (rv !== 32'h24681357) begin failures++; $display("FAIL rst_access_mem got=%h exp=24681357", rv); end
  endtask

  task automatic test_back_to_back();
    int n, at, e; logic [31:0] rv; logic bz;
    do_op(1'b0, 1'b1, 9'h1FF, 32'h89ABCDEF, n, at, e, rv, bz);
    checks++; if (n != 1 || at != 2 || bz !== 1'b0) begin failures++; $display("FAIL b2b_wr pulses=%0d at=%0d busy=%b exp 1/2/0", n, at, bz); end
    do_op(1'b0, 1'b1, 9'h100, 32'h76543210, n, at, e, rv, bz);
    do_op(1'b1, 1'b0, 9'h1FF, 32'h0, n, at, e, rv, bz);
    checks++; if (rv !== 32'h89ABCDEF || n != 1 || at != 2) begin failures++; $display("FAIL b2b_rd_top got=%h pulses=%0d at=%0d exp 89abcdef/1/2", rv, n, at); end
    do_op(1'b1, 1'b0, 9'h100, 32'h0, n, at, e, rv, bz);
    checks++; if (rv !== 32'h76543210) begin failures++; $display("FAIL b2b_rd_mid got=%h exp=76543210", rv); end
  endtask

  task automatic test_protect();
    int n, at, e; logic [31:0] rv, orig; logic bz;
`ifdef MEM_WRITE_PROTECT_EN
    do_op(1'b1, 1'b0, 9'h003, 32'h0, n, at, e, orig, bz);
    bus.write = 1'b1; bus.addr = 9'h003; bus.wdata = 32'h55555555;
    tick(); tick(); tick(); // k+2
    checks++; if (bus.err !== 1'b1 || bus.mem_ready !== 1'b1) begin failures++; $display("FAIL prot_pulse err=%b ready=%b exp 1/1", bus.err, bus.mem_ready); end
    bus.write = 1'b0;
    tick(); tick();
    do_op(1'b1, 1'b0, 9'h003, 32'h0, n, at, e, rv, bz);
    checks++; if (rv !== orig || e != 0) begin failures++; $display("FAIL prot_unchanged got=%h exp=%h", rv, orig); end
    do_op(1'b0, 1'b1, 9'h010, 32'h0F0F0F0F, n, at, e, rv, bz);
    checks++; if (e != 0 || n != 1) begin failures++; $display("FAIL prot_ok_wr err=%0d pulses=%0d exp 0/1", e, n); end
    do_op(1'b1, 1'b0, 9'h010, 32'h0, n, at, e, rv, bz);
    checks++; if (rv !== 32'h0F0F0F0F) begin failures++; $display("FAIL prot_ok_rd got=%h exp=0f0f0f0f", rv); end
`else
    orig = 32'h0;
    do_op(1'b0, 1'b1, 9'h003, 32'h55555555, n, at, e, rv, bz);
    checks++; if (e != 0 || n != 1 || at != 2) begin failures++; $display("FAIL low_wr err=%0d pulses=%0d at=%0d exp 0/1/2", e, n, at); end
    do_op(1'b1, 1'b0, 9'h003, 32'h0, n, at, e, rv, bz);
    checks++; if (rv !== 32'h55555555 || rv === orig) begin failures++; $display("FAIL low_rd got=%h exp=55555555", rv); end
`endif
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_write();
    test_readback();
    test_latch();
    test_simultaneous();
    test_reset_mid();
    test_back_to_back();
    test_protect();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout global time limit reached");
    $fatal(1, "timeout");
  end

endmodule
